// File: rtl/fe_stage_btb.sv
// Fetch stage: holds the PC, predicts next PC with a direct-mapped BTB,
// registers fetched instruction plus metadata into the FE latch.
// Ports:
//   clk, reset            - clock, async active-high reset
//   stall_de_i            - DE asks FE to hold PC and latch
//   redirect_valid_i/target_i - AGEX redirect, flushes the latch
//   btb_update_*          - AGEX writes one BTB entry per cycle
//   imem_addr_o/rdata_i   - instruction memory, same-cycle read
//   fe_*                  - FE latch contents and delivered-inst count
module fe_stage_btb #(
    parameter int          DBITS        = 32,
    parameter int          INSTBITS     = 32,
    parameter logic [31:0] START_PC     = 32'h0000_0200,
    parameter int          BTB_IDX_BITS = 4,
    parameter logic [31:0] NOP_INST     = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall_de_i,
    input  logic                redirect_valid_i,
    input  logic [DBITS-1:0]    redirect_target_i,
    input  logic                btb_update_i,
    input  logic [DBITS-1:0]    btb_update_pc_i,
    input  logic [DBITS-1:0]    btb_update_target_i,
    output logic [DBITS-1:0]    imem_addr_o,
    input  logic [INSTBITS-1:0] imem_rdata_i,
    output logic                fe_valid_o,
    output logic [INSTBITS-1:0] fe_inst_o,
    output logic [DBITS-1:0]    fe_pc_o,
    output logic [DBITS-1:0]    fe_pcplus_o,
    output logic                fe_pred_taken_o,
    output logic [DBITS-1:0]    fe_pred_target_o,
    output logic [DBITS-1:0]    fe_inst_count_o
);

    localparam int ENTRIES = 1 << BTB_IDX_BITS;
    localparam int TAGBITS = DBITS - BTB_IDX_BITS - 2;

    logic [DBITS-1:0]        r_pc;
    logic [ENTRIES-1:0]      r_btb_valid;
    logic [TAGBITS-1:0]      r_btb_tag    [ENTRIES];
    logic [DBITS-1:0]        r_btb_target [ENTRIES];

    logic                    r_valid;
    logic [INSTBITS-1:0]     r_inst;
    logic [DBITS-1:0]        r_fpc;
    logic [DBITS-1:0]        r_fpcplus;
    logic                    r_pred_taken;
    logic [DBITS-1:0]        r_pred_target;
    logic [DBITS-1:0]        r_count;

    logic [BTB_IDX_BITS-1:0] w_idx;
    logic [TAGBITS-1:0]      w_tag;
    logic [BTB_IDX_BITS-1:0] w_upd_idx;
    logic [TAGBITS-1:0]      w_upd_tag;
    logic                    w_hit;
    logic [DBITS-1:0]        w_pcplus;
    logic [DBITS-1:0]        w_next_pc;
    logic [DBITS-1:0]        w_pred_target;
    logic [DBITS-1:0]        w_redirect_pc;

    assign w_idx     = r_pc[BTB_IDX_BITS+1:2];
    assign w_tag     = r_pc[DBITS-1:BTB_IDX_BITS+2];
    assign w_upd_idx = btb_update_pc_i[BTB_IDX_BITS+1:2];
    assign w_upd_tag = btb_update_pc_i[DBITS-1:BTB_IDX_BITS+2];

    // Lookup reads the registered array, so an update written on this
    // edge is not visible to the lookup happening in the same cycle.
    assign w_hit         = r_btb_valid[w_idx] && (r_btb_tag[w_idx] == w_tag);
    assign w_pcplus      = r_pc + DBITS'(4);
    assign w_pred_target = w_hit ? r_btb_target[w_idx] : '0;
    assign w_next_pc     = w_hit ? r_btb_target[w_idx] : w_pcplus;
    assign w_redirect_pc = {redirect_target_i[DBITS-1:2], 2'b00};

    assign imem_addr_o = r_pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_btb_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_btb_tag[i]    <= '0;
                r_btb_target[i] <= '0;
            end
        end else if (btb_update_i) begin
            r_btb_valid[w_upd_idx]  <= 1'b1;
            r_btb_tag[w_upd_idx]    <= w_upd_tag;
            r_btb_target[w_upd_idx] <= btb_update_target_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc          <= DBITS'(START_PC);
            r_valid       <= 1'b0;
            r_inst        <= INSTBITS'(NOP_INST);
            r_fpc         <= '0;
            r_fpcplus     <= '0;
            r_pred_taken  <= 1'b0;
            r_pred_target <= '0;
            r_count       <= '0;
        end else if (redirect_valid_i) begin
            // Redirect wins over stall: the latch becomes one bubble.
            r_pc          <= w_redirect_pc;
            r_valid       <= 1'b0;
            r_inst        <= INSTBITS'(NOP_INST);
            r_fpc         <= '0;
            r_fpcplus     <= '0;
            r_pred_taken  <= 1'b0;
            r_pred_target <= '0;
        end else if (!stall_de_i) begin
            r_pc          <= w_next_pc;
            r_valid       <= 1'b1;
            r_inst        <= imem_rdata_i;
            r_fpc         <= r_pc;
            r_fpcplus     <= w_pcplus;
            r_pred_taken  <= w_hit;
            r_pred_target <= w_pred_target;
            r_count       <= r_count + DBITS'(1);
        end
    end

    assign fe_valid_o       = r_valid;
    assign fe_inst_o        = r_inst;
    assign fe_pc_o          = r_fpc;
    assign fe_pcplus_o      = r_fpcplus;
    assign fe_pred_taken_o  = r_pred_taken;
    assign fe_pred_target_o = r_pred_target;
    assign fe_inst_count_o  = r_count;

endmodule

// File: tb/tb_fe_stage_btb.sv
// Directed bench for fe_stage_btb: reset, advance, stall, redirect,
// BTB hit/alias/same-cycle update, PC wrap and async mid-stream reset.
module tb_fe_stage_btb;

    logic        clk;
    logic        reset;
    logic        stall_de_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_target_i;
    logic        btb_update_i;
    logic [31:0] btb_update_pc_i;
    logic [31:0] btb_update_target_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic        fe_valid_o;
    logic [31:0] fe_inst_o;
    logic [31:0] fe_pc_o;
    logic [31:0] fe_pcplus_o;
    logic        fe_pred_taken_o;
    logic [31:0] fe_pred_target_o;
    logic [31:0] fe_inst_count_o;

    int total = 0;
    int bad   = 0;

    fe_stage_btb dut (
        .clk                 (clk),
        .reset               (reset),
        .stall_de_i          (stall_de_i),
        .redirect_valid_i    (redirect_valid_i),
        .redirect_target_i   (redirect_target_i),
        .btb_update_i        (btb_update_i),
        .btb_update_pc_i     (btb_update_pc_i),
        .btb_update_target_i (btb_update_target_i),
        .imem_addr_o         (imem_addr_o),
        .imem_rdata_i        (imem_rdata_i),
        .fe_valid_o          (fe_valid_o),
        .fe_inst_o           (fe_inst_o),
        .fe_pc_o             (fe_pc_o),
        .fe_pcplus_o         (fe_pcplus_o),
        .fe_pred_taken_o     (fe_pred_taken_o),
        .fe_pred_target_o    (fe_pred_target_o),
        .fe_inst_count_o     (fe_inst_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: address-tagged words.
    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h200) return 32'h0010_0093;
        return {a[23:0], 8'h13};
    endfunction

    assign imem_rdata_i = mem(imem_addr_o);

    // {valid, inst, pc, pcplus, pred_taken, pred_target, count, imem_addr}
    function automatic logic [193:0] obs();
        return {fe_valid_o, fe_inst_o, fe_pc_o, fe_pcplus_o,
                fe_pred_taken_o, fe_pred_target_o, fe_inst_count_o,
                imem_addr_o};
    endfunction

    function automatic logic [193:0] ev(
        input logic v, input logic [31:0] inst, input logic [31:0] pc,
        input logic [31:0] pcp, input logic pt, input logic [31:0] ptg,
        input logic [31:0] cnt, input logic [31:0] addr);
        return {v, inst, pc, pcp, pt, ptg, cnt, addr};
    endfunction

    function automatic logic [193:0] bubble(
        input logic [31:0] cnt, input logic [31:0] addr);
        return {1'b1 ^ 1'b1, 32'h13, 32'h0, 32'h0, 1'b0, 32'h0, cnt, addr};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [193:0] e;
        reset = 1'b1;
        stall_de_i = 1'b0;
        redirect_valid_i = 1'b0;
        redirect_target_i = '0;
        btb_update_i = 1'b0;
        btb_update_pc_i = '0;
        btb_update_target_i = '0;
        #1;
        e = bubble(32'd0, 32'h200);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL reset got %h want %h", obs(), e);
        end
        step();
        step();
        reset = 1'b0;
        step();
        e = ev(1'b1, 32'h0010_0093, 32'h200, 32'h204, 1'b0, 0, 1, 32'h204);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL first_fetch got %h want %h", obs(), e);
        end
    endtask

    task automatic test_stall();
        logic [193:0] e;
        step();
        e = ev(1'b1, mem(32'h204), 32'h204, 32'h208, 1'b0, 0, 2, 32'h208);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL adv2 got %h want %h", obs(), e);
        end
        stall_de_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (obs() !== e) begin
                bad++;
                $display("FAIL stall%0d got %h want %h", i, obs(), e);
            end
        end
        stall_de_i = 1'b0;
        step();
        e = ev(1'b1, mem(32'h208), 32'h208, 32'h20C, 1'b0, 0, 3, 32'h20C);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL stall_release got %h want %h", obs(), e);
        end
    endtask

    task automatic test_redirect();
        logic [193:0] e;
        stall_de_i = 1'b1;
        redirect_valid_i = 1'b1;
        redirect_target_i = 32'h303;
        step();
        stall_de_i = 1'b0;
        redirect_valid_i = 1'b0;
        e = bubble(32'd3, 32'h300);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL redir_bubble got %h want %h", obs(), e);
        end
        step();
        e = ev(1'b1, mem(32'h300), 32'h300, 32'h304, 1'b0, 0, 4, 32'h304);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL redir_fetch got %h want %h", obs(), e);
        end
    endtask

    task automatic test_btb_hit();
        logic [193:0] e;
        btb_update_i = 1'b1;
        btb_update_pc_i = 32'h210;
        btb_update_target_i = 32'h400;
        step();
        btb_update_i = 1'b0;
        e = ev(1'b1, mem(32'h304), 32'h304, 32'h308, 1'b0, 0, 5, 32'h308);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL btb_upd_adv got %h want %h", obs(), e);
        end
        redirect_valid_i = 1'b1;
        redirect_target_i = 32'h20C;
        step();
        redirect_valid_i = 1'b0;
        step();
        e = ev(1'b1, mem(32'h20C), 32'h20C, 32'h210, 1'b0, 0, 6, 32'h210);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL pre_hit got %h want %h", obs(), e);
        end
        step();
        e = ev(1'b1, mem(32'h210), 32'h210, 32'h214, 1'b1, 32'h400, 7,
               32'h400);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL btb_hit got %h want %h", obs(), e);
        end
        step();
        e = ev(1'b1, mem(32'h400), 32'h400, 32'h404, 1'b0, 0, 8, 32'h404);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL post_hit got %h want %h", obs(), e);
        end
    endtask

    task automatic test_alias();
        logic [193:0] e;
        redirect_valid_i = 1'b1;
        redirect_target_i = 32'h250;
        step();
        redirect_valid_i = 1'b0;
        e = bubble(32'd8, 32'h250);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL alias_bubble got %h want %h", obs(), e);
        end
        step();
        e = ev(1'b1, mem(32'h250), 32'h250, 32'h254, 1'b0, 0, 9, 32'h254);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL alias_miss got %h want %h", obs(), e);
        end
        redirect_valid_i = 1'b1;
        redirect_target_i = 32'h210;
        step();
        redirect_valid_i = 1'b0;
        btb_update_i = 1'b1;
        btb_update_pc_i = 32'h250;
        btb_update_target_i = 32'h500;
        step();
        btb_update_i = 1'b0;
        e = ev(1'b1, mem(32'h210), 32'h210, 32'h214, 1'b1, 32'h400, 10,
               32'h400);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL same_cycle_old got %h want %h", obs(), e);
        end
        redirect_valid_i = 1'b1;
        redirect_target_i = 32'h250;
        step();
        redirect_valid_i = 1'b0;
        step();
        e = ev(1'b1, mem(32'h250), 32'h250, 32'h254, 1'b1, 32'h500, 11,
               32'h500);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL alias_overwrite got %h want %h", obs(), e);
        end
    endtask

    task automatic test_wrap();
        logic [193:0] e;
        redirect_valid_i = 1'b1;
        redirect_target_i = 32'hFFFF_FFFC;
        step();
        redirect_valid_i = 1'b0;
        step();
        e = ev(1'b1, 32'hFFFF_FC13, 32'hFFFF_FFFC, 32'h0, 1'b0, 0, 12,
               32'h0);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL pc_wrap got %h want %h", obs(), e);
        end
    endtask

    task automatic test_async_reset();
        logic [193:0] e;
        #2;
        reset = 1'b1;
        #1;
        e = bubble(32'd0, 32'h200);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL async_reset got %h want %h", obs(), e);
        end
        step();
        reset = 1'b0;
        redirect_valid_i = 1'b1;
        redirect_target_i = 32'h210;
        step();
        redirect_valid_i = 1'b0;
        step();
        e = ev(1'b1, mem(32'h210), 32'h210, 32'h214, 1'b0, 0, 1, 32'h214);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL btb_cleared got %h want %h", obs(), e);
        end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_redirect();
        test_btb_hit();
        test_alias();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
